// File: rtl/arb_mux_2ch_pkg.sv
// Shared constants for the two-channel round-robin arbitrating multiplexer.
// Source encoding is shared by o_src, sel and the `last` history register.
package arb_mux_2ch_pkg;

    typedef logic src_t;

    localparam src_t SRC_X    = 1'b0;
    localparam src_t SRC_Y    = 1'b1;

    // X must win the first contention after reset, so history starts on Y.
    localparam src_t LAST_RST = SRC_Y;

endpackage : arb_mux_2ch_pkg

// File: rtl/arb_mux_2ch_rr2_arbiter.sv
// Combinational two-way round-robin grant with a select that a plain
// 2:1 data mux can follow even when no transfer takes place.
module arb_mux_2ch_rr2_arbiter
    import arb_mux_2ch_pkg::*;
(
    input  logic x_valid_i,
    input  logic y_valid_i,
    input  logic last_i,
    input  logic space_i,
    output logic grant_x_o,
    output logic grant_y_o,
    output logic sel_o
);

    logic pick_x_s;
    logic pick_y_s;

    // Choose a winner from the offered channels and the previous winner.
    always_comb begin
        pick_x_s = 1'b0;
        pick_y_s = 1'b0;
        sel_o    = ~last_i;
        case ({x_valid_i, y_valid_i})
            2'b10: begin
                pick_x_s = 1'b1;
                sel_o    = SRC_X;
            end
            2'b01: begin
                pick_y_s = 1'b1;
                sel_o    = SRC_Y;
            end
            2'b11: begin
                if (last_i == SRC_Y) begin
                    pick_x_s = 1'b1;
                end else begin
                    pick_y_s = 1'b1;
                end
                sel_o = ~last_i;
            end
            default: begin
                pick_x_s = 1'b0;
                pick_y_s = 1'b0;
                sel_o    = ~last_i;
            end
        endcase
    end

    // A grant only turns into ready when the output stage can load.
    always_comb begin
        grant_x_o = space_i & pick_x_s;
        grant_y_o = space_i & pick_y_s;
    end

endmodule : arb_mux_2ch_rr2_arbiter

// File: rtl/arb_mux_2ch.sv
// Two-channel round-robin arbitrating mux with a single registered output
// stage tagged with its source, plus saturating per-channel grant counters.
module arb_mux_2ch
    import arb_mux_2ch_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_valid,
    input  logic [WIDTH-1:0] x_data,
    output logic             x_ready,
    input  logic             y_valid,
    input  logic [WIDTH-1:0] y_data,
    output logic             y_ready,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_src,
    output logic             sel,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] x_cnt,
    output logic [CNT_W-1:0] y_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] o_data_q,  o_data_d;
    src_t             o_src_q,   o_src_d;
    src_t             last_q,    last_d;
    logic [CNT_W-1:0] x_cnt_q,   x_cnt_d;
    logic [CNT_W-1:0] y_cnt_q,   y_cnt_d;

    logic             space_s;
    logic             grant_x_s;
    logic             grant_y_s;
    logic             sel_s;
    logic             xfer_s;
    logic [WIDTH-1:0] data_sel_s;

    // Output stage can load when empty or draining; nothing is accepted in reset.
    always_comb begin
        space_s = (~o_valid_q | o_ready) & ~rst;
    end

    arb_mux_2ch_rr2_arbiter u_rr2_arbiter (
        .x_valid_i (x_valid),
        .y_valid_i (y_valid),
        .last_i    (last_q),
        .space_i   (space_s),
        .grant_x_o (grant_x_s),
        .grant_y_o (grant_y_s),
        .sel_o     (sel_s)
    );

    // Datapath follows the exported select so external muxes stay in step.
    always_comb begin
        data_sel_s = sel_s ? y_data : x_data;
        xfer_s     = grant_x_s | grant_y_s;
    end

    // Next state of the output register and round-robin history.
    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_src_d   = o_src_q;
        last_d    = last_q;
        if (xfer_s) begin
            o_valid_d = 1'b1;
            o_data_d  = data_sel_s;
            o_src_d   = grant_y_s ? SRC_Y : SRC_X;
            last_d    = grant_y_s ? SRC_Y : SRC_X;
        end else if (o_valid_q & o_ready) begin
            o_valid_d = 1'b0;
        end else begin
            o_valid_d = o_valid_q;
        end
    end

    // Grant counters: clear wins over a same-cycle increment.
    always_comb begin
        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        if (cnt_clr) begin
            x_cnt_d = {CNT_W{1'b0}};
            y_cnt_d = {CNT_W{1'b0}};
        end else begin
            if (grant_x_s && (x_cnt_q != CNT_MAX)) begin
                x_cnt_d = x_cnt_q + CNT_ONE;
            end else begin
                x_cnt_d = x_cnt_q;
            end
            if (grant_y_s && (y_cnt_q != CNT_MAX)) begin
                y_cnt_d = y_cnt_q + CNT_ONE;
            end else begin
                y_cnt_d = y_cnt_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            o_data_q  <= {WIDTH{1'b0}};
            o_src_q   <= SRC_X;
            last_q    <= LAST_RST;
            x_cnt_q   <= {CNT_W{1'b0}};
            y_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_src_q   <= o_src_d;
            last_q    <= last_d;
            x_cnt_q   <= x_cnt_d;
            y_cnt_q   <= y_cnt_d;
        end
    end

    // Drive ports from the registered state and the combinational grant.
    always_comb begin
        x_ready = grant_x_s;
        y_ready = grant_y_s;
        sel     = sel_s;
        o_valid = o_valid_q;
        o_data  = o_data_q;
        o_src   = o_src_q;
        x_cnt   = x_cnt_q;
        y_cnt   = y_cnt_q;
    end

endmodule : arb_mux_2ch
